// File: rtl/dbscan_cluster_stats.sv
`default_nettype none
// ============================================================================
// Module   : dbscan_cluster_stats
// Purpose  : Scans a labelled point memory once and emits one count/bounding-box
//            record per non-empty cluster label in ascending label order.
// Revision : 1.0
// ============================================================================
module dbscan_cluster_stats #(
   parameter int N = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [3:0] raddr,
   input  logic [7:0] px,
   input  logic [7:0] py,
   input  logic [7:0] pz,
   input  logic [3:0] plabel,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_label,
   output logic [4:0] out_count,
   output logic [7:0] out_xmin,
   output logic [7:0] out_xmax,
   output logic [7:0] out_ymin,
   output logic [7:0] out_ymax,
   output logic [7:0] out_zmin,
   output logic [7:0] out_zmax,
   output logic [4:0] noise_count,
   output logic       busy,
   output logic       finish
);

   localparam logic [3:0] C_LAST_IDX = 4'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_EMIT = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t     r_state;
   logic [3:0] r_idx;
   logic [3:0] r_ptr;
   logic [4:0] r_noise;
   // Entry 0 is never accumulated (label 0 is noise); it only keeps indexing simple.
   logic [4:0] r_cnt  [0:15];
   logic [7:0] r_xmin [0:15];
   logic [7:0] r_xmax [0:15];
   logic [7:0] r_ymin [0:15];
   logic [7:0] r_ymax [0:15];
   logic [7:0] r_zmin [0:15];
   logic [7:0] r_zmax [0:15];

   logic       w_rec_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= 4'd0;
         r_ptr   <= 4'd0;
         r_noise <= 5'd0;
         for (int l = 0; l < 16; l++) begin
            r_cnt[l]  <= 5'd0;
            r_xmin[l] <= 8'hFF;
            r_xmax[l] <= 8'h00;
            r_ymin[l] <= 8'hFF;
            r_ymax[l] <= 8'h00;
            r_zmin[l] <= 8'hFF;
            r_zmax[l] <= 8'h00;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_SCAN;
                  r_idx   <= 4'd0;
                  r_noise <= 5'd0;
                  for (int l = 0; l < 16; l++) begin
                     r_cnt[l]  <= 5'd0;
                     r_xmin[l] <= 8'hFF;
                     r_xmax[l] <= 8'h00;
                     r_ymin[l] <= 8'hFF;
                     r_ymax[l] <= 8'h00;
                     r_zmin[l] <= 8'hFF;
                     r_zmax[l] <= 8'h00;
                  end
               end
            end
            S_SCAN: begin
               if (plabel == 4'd0) begin
                  r_noise <= r_noise + 5'd1;
               end else begin
                  r_cnt[plabel] <= r_cnt[plabel] + 5'd1;
                  if (px < r_xmin[plabel]) r_xmin[plabel] <= px;
                  if (px > r_xmax[plabel]) r_xmax[plabel] <= px;
                  if (py < r_ymin[plabel]) r_ymin[plabel] <= py;
                  if (py > r_ymax[plabel]) r_ymax[plabel] <= py;
                  if (pz < r_zmin[plabel]) r_zmin[plabel] <= pz;
                  if (pz > r_zmax[plabel]) r_zmax[plabel] <= pz;
               end
               if (r_idx == C_LAST_IDX) begin
                  r_state <= S_EMIT;
                  r_ptr   <= 4'd1;
               end else begin
                  r_idx <= r_idx + 4'd1;
               end
            end
            S_EMIT: begin
               // Empty labels advance unconditionally; a present record waits for ready.
               if (!w_rec_valid || out_ready) begin
                  if (r_ptr == 4'd15) r_state <= S_FIN;
                  else                r_ptr   <= r_ptr + 4'd1;
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_rec_valid = (r_state == S_EMIT) && (r_cnt[r_ptr] != 5'd0);

   assign raddr       = (r_state == S_SCAN) ? r_idx : 4'd0;
   assign out_valid   = w_rec_valid;
   assign out_label   = w_rec_valid ? r_ptr         : 4'd0;
   assign out_count   = w_rec_valid ? r_cnt[r_ptr]  : 5'd0;
   assign out_xmin    = w_rec_valid ? r_xmin[r_ptr] : 8'd0;
   assign out_xmax    = w_rec_valid ? r_xmax[r_ptr] : 8'd0;
   assign out_ymin    = w_rec_valid ? r_ymin[r_ptr] : 8'd0;
   assign out_ymax    = w_rec_valid ? r_ymax[r_ptr] : 8'd0;
   assign out_zmin    = w_rec_valid ? r_zmin[r_ptr] : 8'd0;
   assign out_zmax    = w_rec_valid ? r_zmax[r_ptr] : 8'd0;
   assign noise_count = r_noise;
   assign busy        = (r_state != S_IDLE);
   assign finish      = (r_state == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_dbscan_cluster_stats.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dbscan_cluster_stats
// Purpose  : Table-driven and randomized bench for dbscan_cluster_stats with a
//            per-label reference model built from the point memory contents.
// Revision : 1.0
// ============================================================================
module tb_dbscan_cluster_stats;

   typedef struct packed {
      logic [3:0] label;
      logic [4:0] cnt;
      logic [7:0] xmin, xmax, ymin, ymax, zmin, zmax;
   } rec_t;

   typedef struct {
      int   kind;
      int   stall_label;
      int   stall_n;
      bit   mid_start;
      bit   rand_ready;
      int   exp_nrec;
      int   exp_noise;
      int   exp_lat;
      rec_t exp_first;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       out_ready = 1'b1;
   logic [3:0] raddr, plabel, out_label;
   logic [7:0] px, py, pz;
   logic       out_valid, busy, finish;
   logic [4:0] out_count, noise_count;
   logic [7:0] out_xmin, out_xmax, out_ymin, out_ymax, out_zmin, out_zmax;

   logic [7:0] mx [16];
   logic [7:0] my [16];
   logic [7:0] mz [16];
   logic [3:0] ml [16];

   rec_t       dut_rec;
   rec_t       q[$];
   int         errors = 0;
   int         checks = 0;
   vec_t       tbl[6];

   always #5 clk = ~clk;

   assign px      = mx[raddr];
   assign py      = my[raddr];
   assign pz      = mz[raddr];
   assign plabel  = ml[raddr];
   assign dut_rec = {out_label, out_count, out_xmin, out_xmax, out_ymin, out_ymax, out_zmin, out_zmax};

   dbscan_cluster_stats #(.N(16)) dut (
      .clk(clk), .rst(rst), .start(start), .raddr(raddr),
      .px(px), .py(py), .pz(pz), .plabel(plabel),
      .out_valid(out_valid), .out_ready(out_ready), .out_label(out_label),
      .out_count(out_count), .out_xmin(out_xmin), .out_xmax(out_xmax),
      .out_ymin(out_ymin), .out_ymax(out_ymax), .out_zmin(out_zmin), .out_zmax(out_zmax),
      .noise_count(noise_count), .busy(busy), .finish(finish)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic rec_t mk_rec(input int l, input int c, input int xn, input int xx,
                                   input int yn, input int yx, input int zn, input int zx);
      rec_t r;
      r.label = 4'(l); r.cnt  = 5'(c);
      r.xmin  = 8'(xn); r.xmax = 8'(xx);
      r.ymin  = 8'(yn); r.ymax = 8'(yx);
      r.zmin  = 8'(zn); r.zmax = 8'(zx);
      return r;
   endfunction

   task automatic load(input int kind);
      for (int i = 0; i < 16; i++) begin
         mx[i] = 8'($urandom); my[i] = 8'($urandom); mz[i] = 8'($urandom);
         ml[i] = 4'd0;
         case (kind)
            1: begin
               if (i < 8) begin
                  ml[i] = 4'd2; mx[i] = 8'(10 + i); my[i] = 8'd5; mz[i] = 8'(200 + i);
               end else begin
                  ml[i] = 4'd5; mx[i] = 8'd0; my[i] = 8'd0; mz[i] = 8'd0;
               end
            end
            2: begin
               ml[i] = 4'd15; mx[i] = (i % 2 == 1) ? 8'd255 : 8'd0; my[i] = 8'(i); mz[i] = 8'd0;
            end
            3: if (i == 3) begin
               ml[i] = 4'd9; mx[i] = 8'd7; my[i] = 8'd8; mz[i] = 8'd9;
            end
            4: ml[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
            default: ;
         endcase
      end
   endtask

   // Reference: per label, gather its points and take count/min/max directly.
   task automatic build_model(output int noise);
      rec_t r;
      int   c;
      q.delete();
      noise = 0;
      for (int i = 0; i < 16; i++) if (ml[i] == 4'd0) noise++;
      for (int l = 1; l < 16; l++) begin
         r = mk_rec(l, 0, 255, 0, 255, 0, 255, 0);
         c = 0;
         for (int i = 0; i < 16; i++) begin
            if (int'(ml[i]) == l) begin
               c++;
               if (mx[i] < r.xmin) r.xmin = mx[i];
               if (mx[i] > r.xmax) r.xmax = mx[i];
               if (my[i] < r.ymin) r.ymin = my[i];
               if (my[i] > r.ymax) r.ymax = my[i];
               if (mz[i] < r.zmin) r.zmin = mz[i];
               if (mz[i] > r.zmax) r.zmax = mz[i];
            end
         end
         r.cnt = 5'(c);
         if (c > 0) q.push_back(r);
      end
   endtask

   // Cycle numbering counts the cycle carrying the start pulse as cycle 1.
   task automatic run_case(input vec_t v);
      int   noise_exp, cyc, stall_left, nacc, lat;
      bit   prev_stall, done;
      rec_t prev, r;
      load(v.kind);
      build_model(noise_exp);
      @(negedge clk); start = 1'b1; out_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 2; stall_left = v.stall_n; nacc = 0; lat = 0;
      prev_stall = 1'b0; done = 1'b0; prev = '0;
      while (!done && cyc < 300) begin
         if (!out_valid) chk("data_zero_when_invalid", 64'(dut_rec), 64'd0);
         if (prev_stall) chk("record_stable_in_stall", {out_valid, dut_rec}, {1'b1, prev});
         if (finish) begin done = 1'b1; lat = cyc; end
         if (v.rand_ready) out_ready = 1'($urandom_range(0, 1));
         else if (out_valid && int'(out_label) == v.stall_label && stall_left > 0) begin
            out_ready = 1'b0; stall_left--;
         end else out_ready = 1'b1;
         start = v.mid_start && (cyc == 20);
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("extra_record", 64'(dut_rec), 64'd0);
            else begin
               r = q.pop_front();
               chk("record", 64'(dut_rec), 64'(r));
               if (nacc == 0 && v.exp_nrec > 0) chk("first_record", 64'(dut_rec), 64'(v.exp_first));
            end
            nacc++;
         end
         prev_stall = out_valid && !out_ready;
         prev = dut_rec;
         if (!done) begin @(negedge clk); cyc++; end
      end
      start = 1'b0; out_ready = 1'b1;
      if (!done) chk("finish_timeout", 64'(cyc), 64'd0);
      else begin
         chk("busy_at_finish", 64'(busy), 64'd1);
         chk("noise_count", 64'(noise_count), 64'(noise_exp));
         if (v.exp_noise >= 0) chk("noise_count_table", 64'(noise_count), 64'(v.exp_noise));
         chk("records_missing", 64'(q.size()), 64'd0);
         if (v.exp_nrec >= 0) chk("record_total", 64'(nacc), 64'(v.exp_nrec));
         if (v.exp_lat > 0) chk("finish_latency", 64'(lat), 64'(v.exp_lat));
         @(negedge clk);
         chk("finish_one_cycle", {finish, busy, out_valid}, 64'd0);
         chk("noise_hold", 64'(noise_count), 64'(noise_exp));
      end
   endtask

   initial begin
      int  n;
      bit  seen;
      vec_t rv;
      for (int i = 0; i < 16; i++) begin mx[i] = 0; my[i] = 0; mz[i] = 0; ml[i] = 0; end
      //        kind stl_lbl stl_n mid  rnd  nrec noise lat first
      tbl[0] = '{0, 0, 0, 1'b0, 1'b0, 0, 16, 33, mk_rec(0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[1] = '{1, 0, 0, 1'b0, 1'b0, 2,  0, 33, mk_rec(2, 8, 10, 17, 5, 5, 200, 207)};
      tbl[2] = '{1, 2, 5, 1'b0, 1'b0, 2,  0, 38, mk_rec(2, 8, 10, 17, 5, 5, 200, 207)};
      tbl[3] = '{2, 0, 0, 1'b0, 1'b0, 1,  0, 33, mk_rec(15, 16, 0, 255, 0, 15, 0, 0)};
      tbl[4] = '{3, 0, 0, 1'b0, 1'b0, 1, 15, 33, mk_rec(9, 1, 7, 7, 8, 8, 9, 9)};
      tbl[5] = '{1, 0, 0, 1'b1, 1'b0, 2,  0, 33, mk_rec(2, 8, 10, 17, 5, 5, 200, 207)};

      @(negedge clk);
      chk("reset_state", {raddr, out_valid, 57'(dut_rec), noise_count, busy, finish}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 6; t++) run_case(tbl[t]);

      // Reset in the middle of a scan, then a fresh run must show no stale state.
      load(0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (raddr != 4'd7 && n < 40) begin @(negedge clk); n++; end
      chk("scan_reaches_index7", 64'(raddr), 64'd7);
      chk("noise_before_reset", 64'(noise_count), 64'd7);
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", {raddr, out_valid, 57'(dut_rec), noise_count, busy, finish}, 64'd0);
      @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid || busy || finish) seen = 1'b1;
      end
      chk("idle_after_reset", 64'(seen), 64'd0);
      run_case(tbl[1]);

      // Randomized labels, coordinates and ready pattern.
      for (int k = 0; k < 8; k++) begin
         rv = '{4, 0, 0, 1'b0, 1'b1, -1, -1, 0, mk_rec(0, 0, 0, 0, 0, 0, 0, 0)};
         run_case(rv);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dbscan_cluster_stats.md
DBSCAN_CLUSTER_STATS -- requirements
Module: dbscan_cluster_stats

Interface
REQ-001 Parameter N, default 16: number of points in point memory; index width 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse, driven by the clustering engine's done output; begins a statistics run.
REQ-005 raddr  output  4  point-memory read index.
REQ-006 px, py, pz  input  8 each  coordinates of point raddr, valid in the same cycle (combinational memory read).
REQ-007 plabel  input  4  cluster label of point raddr; 0 = noise, 1..15 = cluster ID.
REQ-008 out_valid  output  1  cluster record valid.
REQ-009 out_ready  input  1  downstream accepts the record.
REQ-010 out_label  output  4  cluster ID of the record.
REQ-011 out_count  output  5  number of points in the cluster, 1..16.
REQ-012 out_xmin, out_xmax, out_ymin, out_ymax, out_zmin, out_zmax  output  8 each  axis-aligned bounding box of the cluster, unsigned.
REQ-013 noise_count  output  5  points labelled 0 in the last completed scan.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 finish  output  1  one-cycle pulse when all records have been emitted.

Function
REQ-016 FSM states: IDLE, SCAN, EMIT, FIN.
REQ-017 IDLE: start=1 -> SCAN. Scan index := 0. All 15 per-label counts := 0. All mins := 255. All maxes := 0. noise_count := 0.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 SCAN: raddr = scan index; each cycle, the point at raddr is accumulated into the entry selected by plabel.
  - plabel=0: noise_count increments.
  - plabel=L, L>0: count[L] increments; min/max per axis updated by unsigned compare.
REQ-020 SCAN SHALL last exactly N cycles (indices 0..N-1). After index N-1 is accumulated: -> EMIT, emit pointer := 1.
REQ-021 raddr SHALL hold 0 outside SCAN.
REQ-022 EMIT, count[ptr]=0: out_valid stays 0 and ptr advances by one per cycle (one empty label skipped per cycle).
REQ-023 EMIT, count[ptr]>0: out_valid=1 and out_label=ptr; out_count and bbox outputs come from entry ptr.
REQ-024 The record SHALL be held stable until the cycle in which out_valid and out_ready are both 1; ptr advances on that cycle.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 Records SHALL be emitted in ascending label order, one record per non-empty label, with no duplicates.
REQ-027 After ptr=15 is skipped or handshaken: -> FIN.
REQ-028 FIN: finish=1 for exactly one cycle, then -> IDLE.
REQ-029 noise_count SHALL hold its value from the end of SCAN until the next accepted start.
REQ-030 All points noise: EMIT emits nothing and passes through 15 skip cycles. Total latency from start to finish = 1 + N + 15 + 1 cycles.
REQ-031 All N points in one cluster: out_count = N (16 fits in 5 bits without overflow).
REQ-032 Single-point cluster: min = max on each axis.
REQ-033 out_* data outputs SHALL be 0 whenever out_valid=0.

Reset
REQ-034 rst=1 at any time, including mid-SCAN or mid-EMIT, SHALL immediately force:
  - state IDLE
  - all counts and noise_count 0
  - mins 255, maxes 0
  - raddr, out_valid, out_* data, busy, finish all 0.
REQ-035 After rst is released, no record SHALL be emitted until a new start pulse.

Verification
REQ-036 All 16 points label 0, out_ready=1, start pulse -> no out_valid; noise_count=16; finish exactly 33 cycles after start.
REQ-037 Points 0..7 label 2 with x=10..17, y=5, z=200..207; points 8..15 label 5 at (0,0,0) -> two records:
  - label 2: count 8, x 10..17, y 5..5, z 200..207.
  - label 5: count 8, all bounds 0.
  - noise_count=0.
REQ-038 Same data as REQ-037, out_ready held 0 for 5 cycles after label-2 out_valid rises -> record stable for all 5 cycles; label 5 follows only after acceptance; no records dropped.
REQ-039 All points label 15 with x=255 and x=0 mixed -> single record: label 15, count 16, xmin 0, xmax 255.
REQ-040 rst asserted at SCAN index 7, then released, then a fresh start with the REQ-037 data -> results identical to REQ-037; no stale counts.
REQ-041 start pulsed again during EMIT -> ignored; record sequence and finish timing unchanged.
